// File: rtl/reset_sequencer.sv
// reset_sequencer
//   One reset controller per clock domain. All channel resets assert
//   asynchronously from the active-low 'reset' input. Deassertion passes
//   through a SYNC_STAGES-deep synchronizer. Channels are then released one at
//   a time in index order, RELEASE_GAP cycles apart. After a channel has been
//   released, software can request a reset pulse on it. The pulse lasts at
//   least MIN_PULSE cycles and is retriggered by further requests.
//
// Optional feature macro: RST_SEQ_SW_RST_EN
//   Defined     : software reset pulses, per-channel counters and sw_active
//                 are built.
//   Not defined : sw_rst_req is ignored and sw_active is tied to 0.
//                 Release sequencing is identical in both builds.
//
// Ports
//   clk        in   1       domain clock, rising edge
//   reset      in   1       asynchronous active-low hard reset
//   sw_rst_req in   NUM_CH  per-channel software reset request (level)
//   rst_out_n  out  NUM_CH  per-channel active-low reset, registered
//   sw_active  out  NUM_CH  channel is inside a software reset pulse
//   rst_done   out  1       every channel released since the last hard reset
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RELEASE_GAP = 8,
  parameter int MIN_PULSE   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sw_rst_req,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic [NUM_CH-1:0] sw_active,
  output logic              rst_done
);

  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam int IW = $clog2(NUM_CH + 1);
  localparam logic [GW-1:0] GAP_END = GW'(RELEASE_GAP);
  localparam logic [IW-1:0] ALL_REL = IW'(NUM_CH);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  logic [GW-1:0]          gap, gap_nx;
  logic [IW-1:0]          idx, idx_nx;      // number of channels released so far
  logic [NUM_CH-1:0]      rel, rel_nx;      // release mask from sequencing only
  logic [NUM_CH-1:0]      hold_nx;          // channels inside a software pulse next cycle

  // Deassertion synchronizer: ones shift in once the hard reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  // Release sequencer state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HOLD;
      gap   <= '0;
      idx   <= '0;
      rel   <= '0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
      idx   <= idx_nx;
      rel   <= rel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    idx_nx   = idx;
    rel_nx   = rel;
    unique case (state)
      HOLD: begin
        if (sync_ok) begin
          rel_nx[0] = 1'b1;
          idx_nx    = IW'(1);
          gap_nx    = '0;
          state_nx  = RELEASE;
        end
      end
      RELEASE: begin
        if (idx == ALL_REL) begin
          // Last channel was released on the previous edge.
          state_nx = RUN;
        end else if (gap + GW'(1) == GAP_END) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IW'(i)) rel_nx[i] = 1'b1;
          end
          idx_nx = idx + IW'(1);
          gap_nx = '0;
        end else begin
          gap_nx = gap + GW'(1);
        end
      end
      RUN: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = HOLD;
      end
    endcase
  end

`ifdef RST_SEQ_SW_RST_EN
  localparam int PW = $clog2(MIN_PULSE + 1);
  localparam logic [PW-1:0] PULSE_LEN = PW'(MIN_PULSE);

  logic [PW-1:0] pcnt    [NUM_CH];
  logic [PW-1:0] pcnt_nx [NUM_CH];

  // A request is honoured only on a channel the sequencer has already
  // released. HOLD has no released channels, so HOLD requests fall out here too.
  // A new request reloads the counter, which also covers retrigger and
  // held requests.
  always_comb begin
    hold_nx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pcnt_nx[i] = pcnt[i];
      if (sw_rst_req[i] && rel[i]) begin
        pcnt_nx[i] = PULSE_LEN;
      end else if (pcnt[i] != '0) begin
        pcnt_nx[i] = pcnt[i] - PW'(1);
      end
      hold_nx[i] = (pcnt_nx[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) pcnt[i] <= '0;
      sw_active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) pcnt[i] <= pcnt_nx[i];
      sw_active <= hold_nx;
    end
  end
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = ^sw_rst_req;
  assign hold_nx   = '0;
  assign sw_active = '0;
`endif

  // Output registers. Each output comes straight from a flop, so no input can
  // reach an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_out_n <= '0;
      rst_done  <= 1'b0;
    end else begin
      rst_out_n <= rel_nx & ~hold_nx;
      rst_done  <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int RELEASE_GAP = 8;
  localparam int MIN_PULSE   = 4;
`ifdef RST_SEQ_SW_RST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif
  localparam int DONE_EDGE = SYNC_STAGES + 2 + (NUM_CH - 1) * RELEASE_GAP;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] sw_rst_req = '0;
  logic [NUM_CH-1:0] rst_out_n;
  logic [NUM_CH-1:0] sw_active;
  logic              rst_done;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES),
    .RELEASE_GAP(RELEASE_GAP), .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .rst_out_n(rst_out_n), .sw_active(sw_active), .rst_done(rst_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: count edges since reset release, and remember the most
  // recent accepted software request edge for each channel.
  int edge_n = 0;
  int last_req [NUM_CH] = '{default: -1000};

  function automatic int rel_edge(input int k);
    return SYNC_STAGES + 1 + k * RELEASE_GAP;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_n <= 0;
      for (int k = 0; k < NUM_CH; k++) last_req[k] <= -1000;
    end else begin
      edge_n <= edge_n + 1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (SW_EN && sw_rst_req[k] && (edge_n + 1 > rel_edge(k)))
          last_req[k] <= edge_n + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [NUM_CH-1:0] e_out, e_act;
    logic              e_done;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
        e_act[k] = reset && (edge_n < last_req[k] + MIN_PULSE);
        e_out[k] = reset && (edge_n >= rel_edge(k)) && !e_act[k];
      end
      e_done = reset && (edge_n >= DONE_EDGE);
      checks += 3;
      if (rst_out_n !== e_out) begin
        errors++;
        $display("FAIL model_rst_out_n t=%0t edge=%0d got %b want %b", $time, edge_n, rst_out_n, e_out);
      end
      if (sw_active !== e_act) begin
        errors++;
        $display("FAIL model_sw_active t=%0t edge=%0d got %b want %b", $time, edge_n, sw_active, e_act);
      end
      if (rst_done !== e_done) begin
        errors++;
        $display("FAIL model_rst_done t=%0t edge=%0d got %b want %b", $time, edge_n, rst_done, e_done);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Wait until the model reports edge n, then move 2 ns past that edge.
  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    while (edge_n < n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_n != n) begin
      checks++;
      errors++;
      $display("FAIL goto_edge reached %0d want %0d", edge_n, n);
    end
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e_held_out, e_held_act;

    // Reset held low for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    chk("reset_out", 32'(rst_out_n), 32'h0);
    chk("reset_act", 32'(sw_active), 32'h0);
    chk("reset_done", 32'(rst_done), 32'h0);

    // Release 2 ns after a clock edge.
    @(posedge clk);
    #2 reset = 1'b1;
    goto_edge(2);  chk("a_e2_out", 32'(rst_out_n), 32'h0);
    goto_edge(3);  chk("a_e3_out", 32'(rst_out_n), 32'h1);
    goto_edge(10); chk("a_e10_out", 32'(rst_out_n), 32'h1);
    goto_edge(11); chk("a_e11_out", 32'(rst_out_n), 32'h3);
    goto_edge(19); chk("a_e19_out", 32'(rst_out_n), 32'h7);
    goto_edge(27); chk("a_e27_out", 32'(rst_out_n), 32'hF);
    chk("a_e27_done", 32'(rst_done), 32'h0);
    goto_edge(28); chk("a_e28_done", 32'(rst_done), 32'h1);

    // One-cycle request on ch2, sampled at edge 31.
    goto_edge(30);
    @(negedge clk) sw_rst_req = 4'b0100;
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(31);
    chk("sw2_e31_out", 32'(rst_out_n), SW_EN ? 32'hB : 32'hF);
    chk("sw2_e31_act", 32'(sw_active), SW_EN ? 32'h4 : 32'h0);
    goto_edge(34);
    chk("sw2_e34_out", 32'(rst_out_n), SW_EN ? 32'hB : 32'hF);
    chk("sw2_e34_done", 32'(rst_done), 32'h1);
    goto_edge(35);
    chk("sw2_e35_out", 32'(rst_out_n), 32'hF);
    chk("sw2_e35_act", 32'(sw_active), 32'h0);

    // Retrigger ch1: requests sampled at edges 40 and 43.
    goto_edge(39);
    @(negedge clk) sw_rst_req = 4'b0010;
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(42);
    @(negedge clk) sw_rst_req = 4'b0010;
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(46);
    chk("retrig_e46_out", 32'(rst_out_n), SW_EN ? 32'hD : 32'hF);
    chk("retrig_e46_act", 32'(sw_active), SW_EN ? 32'h2 : 32'h0);
    goto_edge(47);
    chk("retrig_e47_out", 32'(rst_out_n), 32'hF);

    // ch0 request held across edges 51..60.
    goto_edge(50);
    @(negedge clk) sw_rst_req = 4'b0001;
    goto_edge(60);
    e_held_out = SW_EN ? 4'b1110 : 4'b1111;
    e_held_act = SW_EN ? 4'b0001 : 4'b0000;
    chk("held_e60_out", 32'(rst_out_n), 32'(e_held_out));
    chk("held_e60_act", 32'(sw_active), 32'(e_held_act));
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(63);
    chk("held_e63_out", 32'(rst_out_n), SW_EN ? 32'hE : 32'hF);
    goto_edge(64);
    chk("held_e64_out", 32'(rst_out_n), 32'hF);
    chk("held_e64_done", 32'(rst_done), 32'h1);

    // Hard reset, then release in the middle of the clock cycle.
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    goto_edge(2); chk("b_e2_out", 32'(rst_out_n), 32'h0);
    goto_edge(3); chk("b_e3_out", 32'(rst_out_n), 32'h1);

    // Request on unreleased ch3 at edge 12, then hard reset at edge 15.
    goto_edge(11);
    @(negedge clk) sw_rst_req = 4'b1000;
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(14);
    chk("b_e14_out", 32'(rst_out_n), 32'h3);
    chk("b_e14_act", 32'(sw_active), 32'h0);
    goto_edge(15);
    #1 reset = 1'b0;
    #1;
    chk("b_async_out", 32'(rst_out_n), 32'h0);
    chk("b_async_act", 32'(sw_active), 32'h0);
    chk("b_async_done", 32'(rst_done), 32'h0);

    // Restarted sequence, again with an ignored ch3 request at edge 12.
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    goto_edge(3); chk("c_e3_out", 32'(rst_out_n), 32'h1);
    goto_edge(11);
    @(negedge clk) sw_rst_req = 4'b1000;
    @(negedge clk) sw_rst_req = 4'b0000;
    goto_edge(26); chk("c_e26_out", 32'(rst_out_n), 32'h7);
    goto_edge(27); chk("c_e27_out", 32'(rst_out_n), 32'hF);
    chk("c_e27_act", 32'(sw_active), 32'h0);
    goto_edge(28); chk("c_e28_done", 32'(rst_done), 32'h1);

    goto_edge(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller that replaces per-module reset handling with one block per clock domain. Asserts all channel resets asynchronously from a single active-low input, deasserts them synchronously through a configurable synchronizer chain, then releases channels one at a time in index order with a fixed gap. Once running, it supports per-channel software-requested reset pulses of guaranteed minimum width. Sits at the top of each clock domain, driving the reset inputs of downstream blocks.

## Interface
- NUM_CH, 4: number of reset channels (≥1).
- SYNC_STAGES, 2: synchronizer flops on reset deassertion (≥2).
- RELEASE_GAP, 8: cycles between consecutive channel releases (≥1).
- MIN_PULSE, 4: software reset pulse width in cycles (≥1).

- clk  in  1  domain clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- sw_rst_req  in  NUM_CH  per-channel software reset request, level-sampled each edge.
- rst_out_n  out  NUM_CH  per-channel active-low reset to downstream logic.
- sw_active  out  NUM_CH  1 while a channel is in a software reset pulse.
- rst_done  out  1  1 when all channels have been released after power-on/hard reset.

## Operation
- Reset values (reset low): rst_out_n = all 0, sw_active = all 0, rst_done = 0, sync chain = all 0, FSM = HOLD, all counters 0. Assertion is immediate and does not depend on clk.
- Sync chain: SYNC_STAGES flops shift in 1 each edge while reset is high; chain output sync_ok.
- FSM states:
  - HOLD: all channels held. On an edge with sync_ok = 1, release ch0 and go to RELEASE, gap counter = 0.
  - RELEASE: gap counter counts 1..RELEASE_GAP; on reaching RELEASE_GAP, release next channel and clear counter. After releasing ch NUM_CH-1, go to RUN on the next edge.
  - RUN: rst_done = 1. Terminal until reset.
- Once released, a channel stays released unless a software pulse or hard reset occurs.
- Software pulse (channel i already released, FSM in RELEASE or RUN): sw_rst_req[i] = 1 at an edge loads channel counter with MIN_PULSE and drives rst_out_n[i] = 0, sw_active[i] = 1. Counter decrements each edge; rst_out_n[i] returns to 1 and sw_active[i] to 0 on the edge where it reaches 0.
- A request sampled during an active pulse reloads the counter (retrigger). A held request keeps the channel in reset.
- Requests on unreleased channels (or in HOLD) are ignored and not queued.
- Software pulses do not clear rst_done and do not affect other channels or release sequencing.
- Hard reset mid-operation (any state, any pulse active): everything returns to reset values and the full sequence restarts from HOLD.
- Counter widths: $clog2(RELEASE_GAP+1) and $clog2(MIN_PULSE+1). No wrap-around is reachable.

## Timing
- Edges counted from the first rising edge after reset rises (edge 1).
- sync_ok is high after edge SYNC_STAGES.
- Channel k is released after edge SYNC_STAGES+1+k·RELEASE_GAP.
- rst_done rises after edge SYNC_STAGES+2+(NUM_CH-1)·RELEASE_GAP.
- Software pulse: a request sampled at edge E drives rst_out_n low after E and high after E+MIN_PULSE (or after last request edge + MIN_PULSE).
- All outputs are registered. No combinational path from any input to any output, except the async reset clear.

## Configuration
- RST_SEQ_SW_RST_EN defined: software pulse logic, per-channel counters, and sw_active behave as above.
- Not defined: sw_rst_req stays in the port list but is ignored, sw_active is tied to 0, and per-channel counters are not built. Release sequencing is unchanged.

## Test plan
- Defaults, reset low 5 cycles then high: rst_out_n = 0000 during reset; bit0 rises after edge 3, bit1 after 11, bit2 after 19, bit3 after 27; rst_done = 1 after edge 28.
- Reset deasserted 2 ns after a clk edge, and separately mid-cycle: release edges are identical (edge 3 for ch0), with no glitch on rst_out_n.
- RUN, sw_rst_req[2] high for 1 cycle at edge E: rst_out_n[2] = 0 and sw_active[2] = 1 for 4 cycles, high again after E+4; other bits stay 1; rst_done stays 1.
- Retrigger: req[1] at E and again at E+3: rst_out_n[1] is low continuously until after E+7.
- req[3] asserted at edge 12 (ch3 unreleased): ignored, ch3 still releases after edge 27. Reset pulled low at edge 15: all outputs 0 immediately, and the sequence restarts from edge 1 after release.
- RST_SEQ_SW_RST_EN undefined: req[0] held high in RUN leaves rst_out_n = 1111 and sw_active = 0000.
